// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / mult-div / redirect hazard sequencer for the 5-stage pipe
// Optional stall counter built only when STALL_COUNT_EN is defined.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  F_D_RS1,
  input  logic [4:0]  F_D_RS2,
  input  logic        fd_use_rs1,
  input  logic        fd_use_rs2,
  input  logic        fd_is_store,
  input  logic [4:0]  D_X_RD,
  input  logic        dx_is_load,
  input  logic        dx_is_md,
  input  logic        x_redirect,
  input  logic        md_ready,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        md_start,
  output logic        md_abort,
  output logic        md_timeout,
  output logic [15:0] stall_cycles
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic             ld_use;

  // A store's RS2 is data only; the W->M memory bypass covers that case.
  always_comb begin
    ld_use = dx_is_load && (D_X_RD != 5'd0) &&
             (((D_X_RD == F_D_RS1) && fd_use_rs1) ||
              ((D_X_RD == F_D_RS2) && fd_use_rs2 && !fd_is_store));
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    md_timeout_d = md_timeout_q;
    stall_pc     = 1'b0;
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_dx    = 1'b0;
    bubble_xm    = 1'b0;
    flush_fd     = 1'b0;
    md_start     = 1'b0;
    md_abort     = 1'b0;

    case (state_q)
      RUN: begin
        if (x_redirect) begin
          flush_fd  = 1'b1;
          bubble_dx = 1'b1;
        end else if (dx_is_md) begin
          md_start   = 1'b1;
          stall_pc   = 1'b1;
          stall_fd   = 1'b1;
          stall_dx   = 1'b1;
          bubble_xm  = 1'b1;
          state_d    = MDWAIT;
          wait_cnt_d = '0;
        end else if (ld_use) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      MDWAIT: begin
        // A result arriving on the last allowed cycle still counts as success.
        if (md_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q < WAIT_LAST) begin
          stall_pc   = 1'b1;
          stall_fd   = 1'b1;
          stall_dx   = 1'b1;
          bubble_xm  = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          md_abort     = 1'b1;
          md_timeout_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset drops every decision output at once, even mid-MDWAIT.
    if (!reset_n) begin
      stall_pc  = 1'b0;
      stall_fd  = 1'b0;
      stall_dx  = 1'b0;
      bubble_dx = 1'b0;
      bubble_xm = 1'b0;
      flush_fd  = 1'b0;
      md_start  = 1'b0;
      md_abort  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  assign md_timeout = md_timeout_q & reset_n;

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_pc && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 16'h0000;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed plus randomized bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  F_D_RS1 = '0, F_D_RS2 = '0, D_X_RD = '0;
  logic        fd_use_rs1 = 0, fd_use_rs2 = 0, fd_is_store = 0;
  logic        dx_is_load = 0, dx_is_md = 0, x_redirect = 0, md_ready = 0;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        md_start, md_abort, md_timeout;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: is a mult/div in flight, which wait cycle (1-based), sticky timeout, stall total.
  bit          m_busy = 0;
  int          m_elapsed = 0;
  bit          m_to = 0;
  int          m_stalls = 0;
  logic [8:0]  e_upd;

  hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(7)) dut (
    .clock(clock), .reset_n(reset_n),
    .F_D_RS1(F_D_RS1), .F_D_RS2(F_D_RS2),
    .fd_use_rs1(fd_use_rs1), .fd_use_rs2(fd_use_rs2), .fd_is_store(fd_is_store),
    .D_X_RD(D_X_RD), .dx_is_load(dx_is_load), .dx_is_md(dx_is_md),
    .x_redirect(x_redirect), .md_ready(md_ready),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
    .md_start(md_start), .md_abort(md_abort), .md_timeout(md_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit order: pc fd dx bdx bxm flush start abort timeout
  function automatic logic [8:0] outs();
    return {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
            md_start, md_abort, md_timeout};
  endfunction

  function automatic logic [8:0] exp_ctl();
    logic       lu;
    logic [8:0] e;
    e  = '0;
    lu = dx_is_load && (D_X_RD != 0) &&
         ((D_X_RD == F_D_RS1 && fd_use_rs1) ||
          (D_X_RD == F_D_RS2 && fd_use_rs2 && !fd_is_store));
    if (!reset_n) return 9'b0;
    if (!m_busy) begin
      if (x_redirect)    e = 9'b000101000;
      else if (dx_is_md) e = 9'b111010100;
      else if (lu)       e = 9'b110100000;
    end else if (!md_ready) begin
      if (m_elapsed < TO) e = 9'b111010000;
      else                e[1] = 1'b1;
    end
    e[0] = m_to;
    return e;
  endfunction

  function automatic logic [15:0] exp_sc();
`ifdef STALL_COUNT_EN
    return 16'(m_stalls);
`else
    return 16'h0000;
`endif
  endfunction

  always @(posedge clock) begin
    assert (!(reset_n && x_redirect && dx_is_md))
      else $error("FAIL excl: x_redirect and dx_is_md both high");
    e_upd = exp_ctl();
    if (!reset_n) begin
      m_busy = 0; m_elapsed = 0; m_to = 0; m_stalls = 0;
    end else begin
      if (e_upd[8] && m_stalls < 65535) m_stalls++;
      if (!m_busy) begin
        if (!x_redirect && dx_is_md) begin
          m_busy = 1; m_elapsed = 1;
        end
      end else if (md_ready) begin
        m_busy = 0;
      end else if (m_elapsed == TO) begin
        m_busy = 0; m_to = 1;
      end else begin
        m_elapsed++;
      end
    end
  end

  task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic st, input logic [4:0] rd, input logic ld,
                       input logic md, input logic redir, input logic rdy);
    @(negedge clock);
    F_D_RS1 = rs1; F_D_RS2 = rs2; fd_use_rs1 = u1; fd_use_rs2 = u2; fd_is_store = st;
    D_X_RD = rd; dx_is_load = ld; dx_is_md = md; x_redirect = redir; md_ready = rdy;
    #1;
    check("ctl", 32'(outs()), 32'(exp_ctl()));
    check("stall_cycles", 32'(stall_cycles), 32'(exp_sc()));
  endtask

  task automatic set_rst(input logic v);
    @(negedge clock);
    reset_n = v;
    #1;
  endtask

  initial begin
    apply(5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    check("rst_outs", 32'(outs()), 32'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rst(1'b1);

    apply(5, 0, 1, 0, 0, 5, 1, 0, 0, 0);
    check("lu_rs1", 32'({stall_pc, stall_fd, bubble_dx, stall_dx}), 32'h0000_000e);
    apply(5, 0, 1, 0, 0, 5, 0, 0, 0, 0);
    check("lu_clear", 32'(stall_pc), 32'd0);
    apply(0, 7, 0, 1, 1, 7, 1, 0, 0, 0);
    check("store_nostall", 32'(stall_pc), 32'd0);
    apply(0, 3, 1, 0, 0, 0, 1, 0, 0, 0);
    check("r0_nostall", 32'(stall_pc), 32'd0);
    apply(5, 0, 1, 0, 0, 5, 1, 0, 1, 0);
    check("redir_lu", 32'({flush_fd, bubble_dx, stall_pc}), 32'h0000_0006);

    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("md_start", 32'({md_start, stall_pc, stall_dx, bubble_xm}), 32'h0000_000f);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("md_wait", 32'({md_start, stall_pc}), 32'h0000_0001);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("md_ready", 32'({stall_pc, stall_fd, stall_dx, bubble_xm, md_abort}), 32'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef STALL_COUNT_EN
    check("md_count", 32'(stall_cycles), 32'd5);
`else
    check("md_count", 32'(stall_cycles), 32'd0);
`endif

    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("to_wait", 32'({md_abort, stall_pc}), 32'h0000_0001);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("md_abort", 32'({md_abort, stall_pc}), 32'h0000_0002);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("to_sticky", 32'({md_timeout, md_abort}), 32'h0000_0002);

    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mid_wait2", 32'(stall_pc), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid", 32'(outs()), 32'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rst(1'b1);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("post_rst_start", 32'({md_start, md_timeout}), 32'h0000_0002);

    for (int n = 0; n < 600; n++) begin
      logic redir, md;
      redir = ($urandom_range(0, 7) == 0);
      md    = !redir && ($urandom_range(0, 7) == 0);
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            md, redir, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
